// File: rtl/io_window_pkg.sv
// Shared types and constants for the Dock I/O window decoder: window entry layout,
// register map offsets, CTRL/STATUS bit positions and the decode FSM state type.
package io_window_pkg;

  localparam int WIN_ADDR_W = 8;
  localparam int SLOT_W     = 3;

  typedef struct packed {
    logic                  en;
    logic [SLOT_W-1:0]     slot;
    logic [WIN_ADDR_W-1:0] mask;
    logic [WIN_ADDR_W-1:0] base;
  } window_t;

  // Register indices above the window table, relative to NUM_WIN
  localparam int IDX_CTRL_OFS   = 0;
  localparam int IDX_STATUS_OFS = 1;
  localparam int IDX_MISS_OFS   = 2;

  localparam int CTRL_LOCK_BIT    = 0;
  localparam int CTRL_DEC_EN_BIT  = 1;
  localparam int STAT_OVERLAP_BIT = 0;
  localparam int STAT_CFG_ERR_BIT = 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } fsm_state_e;

endpackage

// File: rtl/io_window_decoder_if.sv
// CPU I/O cycle, config port and decode result bundle for io_window_decoder.
interface io_window_decoder_if #(
  parameter int NUM_WIN = 8,
  parameter int ADDR_W  = 8
);
  localparam int IDX_W = $clog2(NUM_WIN) + 2;
  localparam int DW    = 2*ADDR_W + 4;

  logic              iorq_n;
  logic [ADDR_W-1:0] addr;
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_addr;
  logic [DW-1:0]     cfg_wdata;
  logic [DW-1:0]     cfg_rdata;
  logic              win_valid;
  logic [2:0]        sel_slot;
  logic              cfg_locked;

  modport slave (
    input  iorq_n, addr, cfg_we, cfg_addr, cfg_wdata,
    output cfg_rdata, win_valid, sel_slot, cfg_locked
  );

  modport master (
    output iorq_n, addr, cfg_we, cfg_addr, cfg_wdata,
    input  cfg_rdata, win_valid, sel_slot, cfg_locked
  );

endinterface

// File: rtl/io_window_match.sv
// Combinational window matcher: per-window hit, lowest-index slot select and
// a flag raised when more than one window claims the address.
module io_window_match
  import io_window_pkg::*;
#(
  parameter int NUM_WIN = 8
) (
  input  window_t               i_win [NUM_WIN],
  input  logic [WIN_ADDR_W-1:0] i_addr,
  output logic                  o_any_hit,
  output logic                  o_multi_hit,
  output logic [SLOT_W-1:0]     o_slot
);

  logic [NUM_WIN-1:0] w_hit;

  always_comb begin
    for (int i = 0; i < NUM_WIN; i++) begin
      w_hit[i] = i_win[i].en & ((i_addr & i_win[i].mask) == (i_win[i].base & i_win[i].mask));
    end
  end

  // NOTE: o_slot gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    o_slot = '0;
    for (int i = NUM_WIN-1; i >= 0; i--) begin
      if (w_hit[i]) o_slot = i_win[i].slot;
    end
  end

  assign o_any_hit   = |w_hit;
  assign o_multi_hit = |(w_hit & (w_hit - NUM_WIN'(1)));

endmodule

// File: rtl/io_window_decoder.sv
// Dock /IORQ address window decoder: programmable window table, held per-cycle slot select.
// Optional miss logging at index NUM_WIN+2 when IO_WINDOW_DECODER_MISS_LOG_EN is defined.
module io_window_decoder
  import io_window_pkg::*;
#(
  parameter int NUM_WIN   = 8,
  parameter int NUM_SLOTS = 5,
  parameter int ADDR_W    = WIN_ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  io_window_decoder_if.slave  bus
);

  localparam int WIN_IDX_W = $clog2(NUM_WIN);
  localparam int IDX_W     = WIN_IDX_W + 2;
  localparam int DW        = 2*ADDR_W + 4;
  localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(NUM_WIN + IDX_CTRL_OFS);
  localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(NUM_WIN + IDX_STATUS_OFS);

  window_t           r_win [NUM_WIN];
  logic              r_dec_en, r_lock, r_overlap, r_cfg_err;
  logic              r_iorq_q, r_win_valid;
  logic [SLOT_W-1:0] r_sel_slot;
  fsm_state_e        r_state;

  window_t              w_wdata_win;
  logic [WIN_IDX_W-1:0] w_win_idx;
  logic                 w_win_sel, w_slot_bad, w_win_we, w_set_cfg_err;
  logic                 w_ctrl_we, w_stat_we, w_fall, w_hit_eval, w_set_overlap;
  logic                 w_any_hit, w_multi_hit;
  logic [SLOT_W-1:0]    w_slot;

  io_window_match #(.NUM_WIN(NUM_WIN)) u_match (
    .i_win       (r_win),
    .i_addr      (bus.addr),
    .o_any_hit   (w_any_hit),
    .o_multi_hit (w_multi_hit),
    .o_slot      (w_slot)
  );

  // Window indices occupy the lower quarter of the index space
  assign w_win_sel     = (bus.cfg_addr[IDX_W-1 -: 2] == 2'b00);
  assign w_win_idx     = bus.cfg_addr[WIN_IDX_W-1:0];
  assign w_wdata_win   = window_t'(bus.cfg_wdata);
  assign w_slot_bad    = w_wdata_win.en && (32'(w_wdata_win.slot) >= NUM_SLOTS);
  assign w_win_we      = bus.cfg_we & w_win_sel & ~r_lock & ~w_slot_bad;
  assign w_set_cfg_err = bus.cfg_we & w_win_sel & (r_lock | w_slot_bad);
  assign w_ctrl_we     = bus.cfg_we & (bus.cfg_addr == IDX_CTRL);
  assign w_stat_we     = bus.cfg_we & (bus.cfg_addr == IDX_STATUS);

  assign w_fall        = (r_state == ST_IDLE) & ~bus.iorq_n & r_iorq_q;
  assign w_hit_eval    = w_fall & r_dec_en & w_any_hit;
  assign w_set_overlap = w_fall & r_dec_en & w_multi_hit;

  // NOTE: the table is a handful of flops with a defined power-up state, so it is reset
  // like any other register rather than treated as an uninitialised RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WIN; i++) r_win[i] <= '0;
    end else if (w_win_we) begin
      r_win[w_win_idx] <= w_wdata_win;
    end
  end

  // NOTE: all clocked state uses non-blocking assignments so every block sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec_en <= 1'b0;
      r_lock   <= 1'b0;
    end else if (w_ctrl_we && !r_lock) begin
      r_dec_en <= bus.cfg_wdata[CTRL_DEC_EN_BIT];
      r_lock   <= bus.cfg_wdata[CTRL_LOCK_BIT];
    end
  end

  // A set event in the same cycle as a write-1-to-clear keeps the bit set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overlap <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_overlap <= (r_overlap & ~(w_stat_we & bus.cfg_wdata[STAT_OVERLAP_BIT])) | w_set_overlap;
      r_cfg_err <= (r_cfg_err & ~(w_stat_we & bus.cfg_wdata[STAT_CFG_ERR_BIT])) | w_set_cfg_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_iorq_q    <= 1'b1;
      r_win_valid <= 1'b0;
      r_sel_slot  <= '0;
    end else begin
      r_iorq_q <= bus.iorq_n;
      case (r_state)
        ST_IDLE: if (w_fall) begin
          r_win_valid <= w_hit_eval;
          r_sel_slot  <= w_hit_eval ? w_slot : '0;
          r_state     <= ST_HOLD;
        end
        ST_HOLD: if (bus.iorq_n) begin
          r_win_valid <= 1'b0;
          r_sel_slot  <= '0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef IO_WINDOW_DECODER_MISS_LOG_EN
  localparam logic [IDX_W-1:0] IDX_MISS = IDX_W'(NUM_WIN + IDX_MISS_OFS);

  logic [ADDR_W-1:0] r_miss_addr;
  logic [7:0]        r_miss_cnt;
  logic              w_miss_eval, w_miss_clr;

  assign w_miss_eval = w_fall & r_dec_en & ~w_any_hit;
  assign w_miss_clr  = bus.cfg_we & (bus.cfg_addr == IDX_MISS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miss_addr <= '0;
      r_miss_cnt  <= '0;
    end else if (w_miss_eval) begin
      r_miss_addr <= bus.addr;
      r_miss_cnt  <= w_miss_clr ? 8'd1 : ((r_miss_cnt == 8'hFF) ? r_miss_cnt : r_miss_cnt + 8'd1);
    end else if (w_miss_clr) begin
      r_miss_addr <= '0;
      r_miss_cnt  <= '0;
    end
  end
`endif

  always_comb begin
    bus.cfg_rdata = '0;
    if (w_win_sel) begin
      bus.cfg_rdata = r_win[w_win_idx];
    end else if (bus.cfg_addr == IDX_CTRL) begin
      bus.cfg_rdata[CTRL_DEC_EN_BIT] = r_dec_en;
      bus.cfg_rdata[CTRL_LOCK_BIT]   = r_lock;
    end else if (bus.cfg_addr == IDX_STATUS) begin
      bus.cfg_rdata[STAT_CFG_ERR_BIT] = r_cfg_err;
      bus.cfg_rdata[STAT_OVERLAP_BIT] = r_overlap;
    end
`ifdef IO_WINDOW_DECODER_MISS_LOG_EN
    else if (bus.cfg_addr == IDX_MISS) begin
      bus.cfg_rdata = DW'({r_miss_cnt, r_miss_addr});
    end
`endif
  end

  assign bus.win_valid  = r_win_valid;
  assign bus.sel_slot   = r_sel_slot;
  assign bus.cfg_locked = r_lock;

endmodule

// File: tb/tb_io_window_decoder.sv
// Directed bench for io_window_decoder: decode latency/hold, priority, overlap, lock,
// slot rejection, status clear races, reset behaviour and (when enabled) miss logging.
module tb_io_window_decoder;

  localparam int NUM_WIN   = 8;
  localparam int NUM_SLOTS = 5;
  localparam int ADDR_W    = 8;

  localparam logic [4:0] IDX_CTRL   = 5'd8;
  localparam logic [4:0] IDX_STATUS = 5'd9;
  localparam logic [4:0] IDX_MISS   = 5'd10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  io_window_decoder_if #(.NUM_WIN(NUM_WIN), .ADDR_W(ADDR_W)) bus ();

  io_window_decoder #(.NUM_WIN(NUM_WIN), .NUM_SLOTS(NUM_SLOTS), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [19:0] rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cfg_write(input logic [4:0] idx, input logic [19:0] data);
    @(negedge clk);
    bus.cfg_addr  = idx;
    bus.cfg_wdata = data;
    bus.cfg_we    = 1'b1;
    @(negedge clk);
    bus.cfg_we    = 1'b0;
  endtask

  task automatic cfg_read(input logic [4:0] idx, output logic [19:0] data);
    bus.cfg_addr = idx;
    #1;
    data = bus.cfg_rdata;
  endtask

  // Returns one clock after the falling edge, when the decode result is visible
  task automatic iorq_begin(input logic [7:0] a);
    @(negedge clk);
    bus.addr   = a;
    bus.iorq_n = 1'b0;
    @(negedge clk);
  endtask

  task automatic iorq_end();
    bus.iorq_n = 1'b1;
    @(negedge clk);
  endtask

  // Config write driven in the same cycle as an /IORQ falling edge
  task automatic cfg_write_on_fall(input logic [4:0] idx, input logic [19:0] data, input logic [7:0] a);
    @(negedge clk);
    bus.cfg_addr  = idx;
    bus.cfg_wdata = data;
    bus.cfg_we    = 1'b1;
    bus.addr      = a;
    bus.iorq_n    = 1'b0;
    @(negedge clk);
    bus.cfg_we    = 1'b0;
  endtask

  initial begin
    bus.iorq_n = 1'b1; bus.addr = '0; bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;

    // Reset state
    #12;
    check("rst_valid", bus.win_valid, 0);
    check("rst_slot", bus.sel_slot, 0);
    check("rst_locked", bus.cfg_locked, 0);
    cfg_read(IDX_CTRL, rd);   check("rst_ctrl", rd, 0);
    cfg_read(IDX_STATUS, rd); check("rst_status", rd, 0);
    cfg_read(5'd0, rd);       check("rst_win0", rd, 0);
    @(negedge clk); rst_n = 1'b1;

    // Basic hit: win0 0x40/0xF0 slot 2, one-clock latency, held, then cleared
    cfg_write(5'd0, 20'hAF040);
    cfg_write(IDX_CTRL, 20'h2);
    cfg_read(5'd0, rd); check("win0_readback", rd, 20'hAF040);
    @(negedge clk);
    bus.addr = 8'h45; bus.iorq_n = 1'b0;
    #1; check("pre_latency_valid", bus.win_valid, 0);
    @(negedge clk);
    check("hit_valid", bus.win_valid, 1);
    check("hit_slot", bus.sel_slot, 2);
    bus.addr = 8'h80;
    repeat (2) @(negedge clk);
    check("hold_valid", bus.win_valid, 1);
    check("hold_slot", bus.sel_slot, 2);
    iorq_end();
    check("release_valid", bus.win_valid, 0);
    check("release_slot", bus.sel_slot, 0);

    // Overlap: win1 0x40/0xFC slot 4 and win3 catch-all slot 1; lowest index wins
    cfg_write(5'd0, 20'h0);
    cfg_write(5'd1, 20'hCFC40);
    cfg_write(5'd3, 20'h90000);
    iorq_begin(8'h41);
    check("overlap_valid", bus.win_valid, 1);
    check("overlap_slot", bus.sel_slot, 4);
    iorq_end();
    cfg_read(IDX_STATUS, rd); check("overlap_set", rd, 20'h1);
    cfg_write(IDX_STATUS, 20'h1);
    cfg_read(IDX_STATUS, rd); check("overlap_w1c", rd, 20'h0);

    // Miss
    cfg_write(5'd3, 20'h0);
    iorq_begin(8'h80);
    check("miss_valid", bus.win_valid, 0);
    check("miss_slot", bus.sel_slot, 0);
    iorq_end();
`ifdef IO_WINDOW_DECODER_MISS_LOG_EN
    cfg_read(IDX_MISS, rd); check("miss_log_first", rd, 20'h00180);
    for (int i = 0; i < 299; i++) begin
      iorq_begin(8'h80);
      iorq_end();
    end
    cfg_read(IDX_MISS, rd); check("miss_log_saturate", rd, 20'h0FF80);
    cfg_write_on_fall(IDX_MISS, 20'h0, 8'h81);
    iorq_end();
    cfg_read(IDX_MISS, rd); check("miss_clear_and_miss", rd, 20'h00181);
    cfg_write(IDX_MISS, 20'h0);
    cfg_read(IDX_MISS, rd); check("miss_clear", rd, 20'h0);
`else
    cfg_read(IDX_MISS, rd); check("miss_idx_disabled", rd, 20'h0);
`endif

    // Unmapped index
    cfg_write(5'd20, 20'hFFFFF);
    cfg_read(5'd20, rd);      check("unmapped_read", rd, 0);
    cfg_read(IDX_STATUS, rd); check("unmapped_no_err", rd, 0);

    // Illegal slot 6 with en=1 is rejected
    cfg_write(5'd2, 20'hEFF10);
    cfg_read(5'd2, rd);       check("bad_slot_rejected", rd, 0);
    cfg_read(IDX_STATUS, rd); check("bad_slot_err", rd, 20'h2);
    cfg_write(IDX_STATUS, 20'h2);
    cfg_read(IDX_STATUS, rd); check("cfg_err_w1c", rd, 0);

    // Reprogramming during HOLD leaves outputs frozen
    cfg_write(5'd0, 20'hAF040);
    iorq_begin(8'h45);
    check("hold_base_slot", bus.sel_slot, 2);
    cfg_write(5'd0, 20'hBF040);
    cfg_write(IDX_CTRL, 20'h0);
    bus.addr = 8'h00;
    check("hold_reprog_valid", bus.win_valid, 1);
    check("hold_reprog_slot", bus.sel_slot, 2);
    iorq_end();
    check("hold_reprog_release", bus.win_valid, 0);
    cfg_write(IDX_CTRL, 20'h2);

    // Config write coincident with falling edge uses the pre-write table
    cfg_write_on_fall(5'd0, 20'hAF040, 8'h45);
    check("same_cycle_prewrite_slot", bus.sel_slot, 3);
    iorq_end();
    iorq_begin(8'h45);
    check("same_cycle_postwrite_slot", bus.sel_slot, 2);
    iorq_end();

    // Overlap set and W1C in the same cycle: set wins
    cfg_write_on_fall(IDX_STATUS, 20'h1, 8'h41);
    check("set_wins_slot", bus.sel_slot, 2);
    iorq_end();
    cfg_read(IDX_STATUS, rd); check("set_wins_status", rd, 20'h1);
    cfg_write(IDX_STATUS, 20'h1);

    // Lock
    cfg_write(IDX_CTRL, 20'h3);
    check("locked", bus.cfg_locked, 1);
    cfg_write(5'd0, 20'hBF040);
    cfg_read(5'd0, rd);       check("locked_table_kept", rd, 20'hAF040);
    cfg_read(IDX_STATUS, rd); check("locked_write_err", rd, 20'h2);
    cfg_write(IDX_CTRL, 20'h0);
    cfg_read(IDX_CTRL, rd);   check("locked_ctrl_kept", rd, 20'h3);
    check("still_locked", bus.cfg_locked, 1);
    iorq_begin(8'h45);
    check("locked_decode_valid", bus.win_valid, 1);

    // Asynchronous reset mid-cycle, /IORQ held low across release
    #2; rst_n = 1'b0;
    #1;
    check("async_rst_valid", bus.win_valid, 0);
    check("async_rst_slot", bus.sel_slot, 0);
    check("async_rst_locked", bus.cfg_locked, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", bus.win_valid, 0);
    cfg_read(5'd0, rd);     check("post_rst_win0", rd, 0);
    cfg_read(IDX_CTRL, rd); check("post_rst_ctrl", rd, 0);
    cfg_write(5'd0, 20'hAF040);
    cfg_write(IDX_CTRL, 20'h2);
    check("post_rst_hold_valid", bus.win_valid, 0);
    iorq_end();
    iorq_begin(8'h45);
    check("post_rst_hit_valid", bus.win_valid, 1);
    check("post_rst_hit_slot", bus.sel_slot, 2);
    iorq_end();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
